coram_multi_timer: RTL and testbench
====================================

// Module: coram_multi_timer
// PURPOSE
//  Parametrised successor to the single free-running cycle timer: NUM_CH independent start/stop/clear cycle
//  counters with sticky overflow, atomic snapshot of all channels, and publication to the control thread
//  through CoramRegisters (one per channel + one sequence register). Sits in userlogic beside datapath
//  blocks; datapath pulses start/stop to time phases, control thread polls the sequence register then reads.
// PARAMETERS
//  NUM_CH        4                 number of timer channels (1..16)
//  W_CNT         32                counter width per channel (<= W_D)
//  W_D           32                CoramRegister data width
//  AUTO_PERIOD   0                 cycles between automatic snapshots; 0 = snapshots only on snap_req
//  THREAD_NAME   "cthread_timer"   CORAM_THREAD_NAME of all registers
//  CORAM_ID_BASE 0                 channel i -> CORAM_ID_BASE+i; sequence reg -> CORAM_ID_BASE+NUM_CH
// PORTS
//  CLK        in   1             clock
//  RST_X      in   1             asynchronous active-low reset
//  ch_start   in   NUM_CH        per-channel start pulse
//  ch_stop    in   NUM_CH        per-channel stop pulse
//  ch_clear   in   NUM_CH        per-channel clear pulse
//  snap_req   in   1             request snapshot + publish
//  running    out  NUM_CH        channel counting
//  ovf        out  NUM_CH        sticky overflow per channel
//  cnt_flat   out  NUM_CH*W_CNT  live counters, ch0 in LSBs
//  snap_busy  out  1             publish FSM not IDLE
//  seq_num    out  W_D           number of completed publishes
// BEHAVIOUR
//  Reset (RST_X=0, async): all counters, running, ovf, shadows, seq_num = 0; FSM=IDLE; pending=0; regs WE=0.
//  Channel, per cycle, priority: clear > stop > start. clear: cnt=0, ovf=0, running unchanged.
//   stop (incl. start&stop same cycle): running=0. start: running=1, counting begins next cycle.
//   running: cnt+1 mod 2^W_CNT; transition all-ones->0 sets ovf (sticky until clear/reset).
//  Snapshot trigger = snap_req | auto tick (AUTO_PERIOD>0: free counter, tick every AUTO_PERIOD cycles).
//  FSM IDLE -> LATCH -> WRDATA -> WRSEQ -> IDLE (3 cycles busy, snap_busy=1 outside IDLE).
//   IDLE: trigger or pending -> LATCH, clear pending.
//   LATCH: shadow[i] = cnt value in this cycle's register (all channels same cycle = atomic).
//   WRDATA: WE=1 on all channel regs, D = {ovf[i] at bit W_D-1 if W_CNT<W_D, zero-ext shadow[i]}.
//   WRSEQ: seq_num+1 (wraps), WE=1 on sequence reg with new value -> seq always written after data.
//  Trigger while busy: pending=1 (one-deep; extra triggers merged). Simultaneous snap_req+tick = one snapshot.
//  Counting never stalls during publish. Reset mid-publish aborts; no partial seq update visible.
// CONFIGURATION
//  COUNTER_SATURATE_EN defined: running counter holds at all-ones instead of wrapping; ovf set on the
//   cycle it would have wrapped; stays saturated until clear. Undefined: wrap-around as above.
// STRUCTURE
//  Shared include coram_timer_pkg.vh: FSM state localparams (IDLE/LATCH/WRDATA/WRSEQ), ovf bit position.
//  Sub-module coram_timer_channel (one counter + running + ovf), generated NUM_CH times;
//  NUM_CH+1 CoramRegister instances generated in top.
// TESTING
//  1 start ch0, 10 cycles, stop -> cnt0=10, running0=0, others 0; start&stop same cycle -> cnt holds.
//  2 W_CNT=4, start ch1, 17 cycles -> wrap: cnt1=1, ovf1=1; saturate build -> cnt1=15, ovf1=1; clear -> 0,0.
//  3 ch0..3 running with offsets, snap_req -> regs 0..3 equal latched values same cycle, seq reg=1 one cycle later.
//  4 snap_req during WRDATA + second in WRSEQ -> exactly one extra publish, seq_num=2.
//  5 AUTO_PERIOD=8, no snap_req, 40 cycles -> 5 publishes, seq_num=5, snap_busy 3 cycles each.
//  6 RST_X low during LATCH -> all outputs 0 immediately, FSM IDLE, seq reg never written.

Source files
------------

// File: rtl/coram_multi_timer_pkg.sv
// Shared definitions for the multi-channel CoRAM cycle timer: publish FSM states and
// the position of the overflow flag inside a published channel word.
package coram_multi_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LATCH  = 2'd1,
        ST_WRDATA = 2'd2,
        ST_WRSEQ  = 2'd3
    } pub_state_e;

    // Overflow flag rides in the MSB of a published word when the counter is narrower.
    function automatic int unsigned ovf_bit_pos(input int unsigned w_d);
        return w_d - 1;
    endfunction

endpackage

// File: rtl/coram_multi_timer_if.sv
// Datapath-side bundle of the multi-channel timer: per-channel start/stop/clear pulses,
// snapshot request, and live status / counter / sequence outputs.
interface coram_multi_timer_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned W_CNT  = 32,
    parameter int unsigned W_D    = 32
);
    logic [NUM_CH-1:0]       ch_start;
    logic [NUM_CH-1:0]       ch_stop;
    logic [NUM_CH-1:0]       ch_clear;
    logic                    snap_req;
    logic [NUM_CH-1:0]       running;
    logic [NUM_CH-1:0]       ovf;
    logic [NUM_CH*W_CNT-1:0] cnt_flat;
    logic                    snap_busy;
    logic [W_D-1:0]          seq_num;

    modport master (
        output ch_start, ch_stop, ch_clear, snap_req,
        input  running, ovf, cnt_flat, snap_busy, seq_num
    );

    modport slave (
        input  ch_start, ch_stop, ch_clear, snap_req,
        output running, ovf, cnt_flat, snap_busy, seq_num
    );
endinterface

// File: rtl/CoramRegister.sv
// Behavioural stand-in for the CoRAM control-thread register: userlogic writes D when WE
// is high; the control thread observes Q. Thread name and id tag the register for the CoRAM flow.
module CoramRegister #(
    parameter string       CORAM_THREAD_NAME = "cthread",
    parameter int unsigned CORAM_ID          = 0,
    parameter int unsigned CORAM_DATA_WIDTH  = 32
) (
    input  logic                        CLK,
    input  logic [CORAM_DATA_WIDTH-1:0] D,
    input  logic                        WE,
    output logic [CORAM_DATA_WIDTH-1:0] Q
);
    logic [CORAM_DATA_WIDTH-1:0] r_q;

    always_ff @(posedge CLK) begin
        if (WE) begin
            r_q <= D;
        end
    end

    assign Q = r_q;
endmodule

// File: rtl/coram_multi_timer_channel.sv
// One timer channel: start/stop/clear controlled cycle counter with sticky overflow.
// COUNTER_SATURATE_EN: hold at all-ones instead of wrapping.
module coram_multi_timer_channel #(
    parameter int unsigned W_CNT = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_clear,
    output logic             o_running,
    output logic             o_ovf,
    output logic [W_CNT-1:0] o_cnt
);
    logic             r_running;
    logic             r_ovf;
    logic [W_CNT-1:0] r_cnt;
    logic             w_at_max;

    assign w_at_max = &r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_running <= 1'b0;
            r_ovf     <= 1'b0;
            r_cnt     <= '0;
        end else if (i_clear) begin
            // clear wins over stop/start and leaves the running flag alone
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (r_running) begin
                if (w_at_max) begin
                    r_ovf <= 1'b1;
`ifdef COUNTER_SATURATE_EN
                    r_cnt <= r_cnt;
`else
                    r_cnt <= '0;
`endif
                end else begin
                    r_cnt <= r_cnt + W_CNT'(1);
                end
            end
            if (i_stop) begin
                r_running <= 1'b0;
            end else if (i_start) begin
                r_running <= 1'b1;
            end
        end
    end

    assign o_running = r_running;
    assign o_ovf     = r_ovf;
    assign o_cnt     = r_cnt;
endmodule

// File: rtl/coram_multi_timer.sv
// NUM_CH start/stop/clear cycle timers with atomic snapshot published through CoRAM registers
// (one per channel, then a sequence register). Optional macro: COUNTER_SATURATE_EN.
module coram_multi_timer
    import coram_multi_timer_pkg::*;
#(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned W_CNT         = 32,
    parameter int unsigned W_D           = 32,
    parameter int unsigned AUTO_PERIOD   = 0,
    parameter string       THREAD_NAME   = "cthread_timer",
    parameter int unsigned CORAM_ID_BASE = 0
) (
    input logic                 CLK,
    input logic                 RST_X,
    coram_multi_timer_if.slave  bus
);
    logic [NUM_CH-1:0][W_CNT-1:0] w_cnt;
    logic [NUM_CH-1:0]            w_running;
    logic [NUM_CH-1:0]            w_ovf;
    logic [NUM_CH-1:0][W_CNT-1:0] r_shadow;
    logic [NUM_CH-1:0]            r_shadow_ovf;
    logic [W_D-1:0]               r_seq_num;
    logic                         r_pending, w_pending_nxt;
    pub_state_e                   r_state, w_state_nxt;
    logic                         w_tick, w_trigger;
    logic                         w_latch, w_wr_data, w_wr_seq;
    logic [NUM_CH:0]              w_reg_we;
    logic [W_D-1:0]               w_reg_d [NUM_CH+1];
    logic [W_D-1:0]               w_reg_q [NUM_CH+1];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        coram_multi_timer_channel #(.W_CNT(W_CNT)) u_ch (
            .i_clk     (CLK),
            .i_rst_n   (RST_X),
            .i_start   (bus.ch_start[gi]),
            .i_stop    (bus.ch_stop[gi]),
            .i_clear   (bus.ch_clear[gi]),
            .o_running (w_running[gi]),
            .o_ovf     (w_ovf[gi]),
            .o_cnt     (w_cnt[gi])
        );
    end

    if (AUTO_PERIOD > 0) begin : g_auto
        localparam int unsigned W_AUTO = $clog2(AUTO_PERIOD + 1);
        logic [W_AUTO-1:0] r_auto_cnt;

        assign w_tick = (r_auto_cnt == W_AUTO'(AUTO_PERIOD - 1));

        always_ff @(posedge CLK or negedge RST_X) begin
            if (!RST_X)      r_auto_cnt <= '0;
            else if (w_tick) r_auto_cnt <= '0;
            else             r_auto_cnt <= r_auto_cnt + W_AUTO'(1);
        end
    end else begin : g_no_auto
        assign w_tick = 1'b0;
    end

    assign w_trigger = bus.snap_req | w_tick;

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_latch       = 1'b0;
        w_wr_data     = 1'b0;
        w_wr_seq      = 1'b0;
        if (r_state != ST_IDLE && w_trigger) begin
            w_pending_nxt = 1'b1;
        end
        case (r_state)
            ST_IDLE: begin
                if (w_trigger || r_pending) begin
                    w_state_nxt   = ST_LATCH;
                    w_pending_nxt = 1'b0;
                end
            end
            ST_LATCH: begin
                w_latch     = 1'b1;
                w_state_nxt = ST_WRDATA;
            end
            ST_WRDATA: begin
                w_wr_data   = 1'b1;
                w_state_nxt = ST_WRSEQ;
            end
            ST_WRSEQ: begin
                w_wr_seq    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_state   <= ST_IDLE;
            r_pending <= 1'b0;
            r_seq_num <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            if (w_wr_seq) begin
                r_seq_num <= w_reg_d[NUM_CH];
            end
        end
    end

    // Overflow flags are latched alongside the counts so a published word is self-consistent.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_shadow     <= '0;
            r_shadow_ovf <= '0;
        end else if (w_latch) begin
            r_shadow     <= w_cnt;
            r_shadow_ovf <= w_ovf;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_data
        if (W_CNT < W_D) begin : g_ovf_bit
            localparam int unsigned OVF_BIT = ovf_bit_pos(W_D);
            assign w_reg_d[gi] = W_D'(r_shadow[gi]) | (W_D'(r_shadow_ovf[gi]) << OVF_BIT);
        end else begin : g_plain
            assign w_reg_d[gi] = W_D'(r_shadow[gi]);
        end
    end

    assign w_reg_d[NUM_CH] = r_seq_num + W_D'(1);
    assign w_reg_we        = {w_wr_seq, {NUM_CH{w_wr_data}}};

    for (genvar gi = 0; gi <= NUM_CH; gi++) begin : g_reg
        CoramRegister #(
            .CORAM_THREAD_NAME (THREAD_NAME),
            .CORAM_ID          (CORAM_ID_BASE + gi),
            .CORAM_DATA_WIDTH  (W_D)
        ) u_reg (
            .CLK (CLK),
            .D   (w_reg_d[gi]),
            .WE  (w_reg_we[gi]),
            .Q   (w_reg_q[gi])
        );
    end

    assign bus.running   = w_running;
    assign bus.ovf       = w_ovf;
    assign bus.cnt_flat  = w_cnt;
    assign bus.snap_busy = (r_state != ST_IDLE);
    assign bus.seq_num   = r_seq_num;
endmodule

// File: tb/tb_coram_multi_timer.sv
// Scoreboard bench for coram_multi_timer: a 4-channel 32-bit instance plus a 2-channel 4-bit
// instance with automatic snapshots; expectations honour COUNTER_SATURATE_EN.
module tb_coram_multi_timer;

    localparam int unsigned NCH   = 4;
    localparam int unsigned WC    = 32;
    localparam int unsigned WD    = 32;
    localparam int unsigned NCH_A = 2;
    localparam int unsigned WC_A  = 4;
    localparam int unsigned WD_A  = 8;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic rst_n_a = 1'b0;
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [WD-1:0]   q_exp   [$];
    logic [WD_A-1:0] q_exp_a [$];

    coram_multi_timer_if #(.NUM_CH(NCH),   .W_CNT(WC),   .W_D(WD))   bus ();
    coram_multi_timer_if #(.NUM_CH(NCH_A), .W_CNT(WC_A), .W_D(WD_A)) bus_a ();

    coram_multi_timer #(
        .NUM_CH(NCH), .W_CNT(WC), .W_D(WD), .AUTO_PERIOD(0),
        .THREAD_NAME("cthread_timer"), .CORAM_ID_BASE(0)
    ) dut (
        .CLK(clk), .RST_X(rst_n), .bus(bus)
    );

    coram_multi_timer #(
        .NUM_CH(NCH_A), .W_CNT(WC_A), .W_D(WD_A), .AUTO_PERIOD(8),
        .THREAD_NAME("cthread_timer"), .CORAM_ID_BASE(8)
    ) dut_a (
        .CLK(clk), .RST_X(rst_n_a), .bus(bus_a)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset();
        bus.ch_start = '0; bus.ch_stop = '0; bus.ch_clear = '0; bus.snap_req = 1'b0;
        bus_a.ch_start = '0; bus_a.ch_stop = '0; bus_a.ch_clear = '0; bus_a.snap_req = 1'b0;
        rst_n = 1'b0; rst_n_a = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.running !== 4'h0) begin n_fail++; $display("FAIL reset_running: got %0h expected 0", bus.running); end
        n_checks++; if (bus.ovf !== 4'h0) begin n_fail++; $display("FAIL reset_ovf: got %0h expected 0", bus.ovf); end
        n_checks++; if (bus.cnt_flat !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0h expected 0", bus.cnt_flat); end
        n_checks++; if (bus.snap_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", bus.snap_busy); end
        n_checks++; if (bus.seq_num !== 32'h0) begin n_fail++; $display("FAIL reset_seq: got %0h expected 0", bus.seq_num); end
        n_checks++; if (bus_a.cnt_flat !== 8'h0) begin n_fail++; $display("FAIL reset_cnt_a: got %0h expected 0", bus_a.cnt_flat); end
        rst_n = 1'b1; rst_n_a = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_count();
        int s;
        bus.ch_start = 4'b0001; s = cyc + 1;
        @(negedge clk);
        bus.ch_start = '0;
        n_checks++; if (bus.running !== 4'b0001) begin n_fail++; $display("FAIL count_running: got %0h expected 1", bus.running); end
        repeat (9) @(negedge clk);
        bus.ch_stop = 4'b0001;
        @(negedge clk);
        bus.ch_stop = '0;
        n_checks++; if (bus.cnt_flat[31:0] !== 32'd10) begin n_fail++; $display("FAIL count_ch0: got %0d expected 10 (start edge %0d)", bus.cnt_flat[31:0], s); end
        n_checks++; if (bus.running !== 4'b0000) begin n_fail++; $display("FAIL count_stopped: got %0h expected 0", bus.running); end
        n_checks++; if (bus.cnt_flat[127:32] !== '0) begin n_fail++; $display("FAIL count_others: got %0h expected 0", bus.cnt_flat[127:32]); end
        bus.ch_start = 4'b0101; bus.ch_stop = 4'b0101;
        @(negedge clk);
        bus.ch_start = '0; bus.ch_stop = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.cnt_flat[31:0] !== 32'd10) begin n_fail++; $display("FAIL startstop_ch0: got %0d expected 10", bus.cnt_flat[31:0]); end
        n_checks++; if (bus.cnt_flat[95:64] !== 32'd0) begin n_fail++; $display("FAIL startstop_ch2: got %0d expected 0", bus.cnt_flat[95:64]); end
        n_checks++; if (bus.running !== 4'b0000) begin n_fail++; $display("FAIL startstop_running: got %0h expected 0", bus.running); end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_cnt;
        logic [7:0] exp_d, got_d;
        bit seen;
`ifdef COUNTER_SATURATE_EN
        exp_cnt = 4'hF;
`else
        exp_cnt = 4'h1;
`endif
        bus_a.ch_start = 2'b10;
        @(negedge clk);
        bus_a.ch_start = '0;
        repeat (16) @(negedge clk);
        bus_a.ch_stop = 2'b10;
        @(negedge clk);
        bus_a.ch_stop = '0;
        n_checks++; if (bus_a.cnt_flat[7:4] !== exp_cnt) begin n_fail++; $display("FAIL wrap_cnt1: got %0h expected %0h", bus_a.cnt_flat[7:4], exp_cnt); end
        n_checks++; if (bus_a.ovf !== 2'b10) begin n_fail++; $display("FAIL wrap_ovf: got %0b expected 10", bus_a.ovf); end
        n_checks++; if (bus_a.cnt_flat[3:0] !== 4'h0) begin n_fail++; $display("FAIL wrap_cnt0: got %0h expected 0", bus_a.cnt_flat[3:0]); end
        q_exp_a.push_back({1'b1, 3'b000, exp_cnt});
        @(negedge clk);
        seen = 1'b0;
        for (int k = 0; k < 24 && !seen; k++) begin
            if (dut_a.w_reg_we[1] === 1'b1) begin
                seen  = 1'b1;
                exp_d = q_exp_a.pop_front();
                got_d = dut_a.w_reg_d[1];
                n_checks++; if (got_d !== exp_d) begin n_fail++; $display("FAIL wrap_pub_ch1: got %0h expected %0h", got_d, exp_d); end
                got_d = dut_a.w_reg_d[0];
                n_checks++; if (got_d !== 8'h00) begin n_fail++; $display("FAIL wrap_pub_ch0: got %0h expected 0", got_d); end
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) begin n_checks++; n_fail++; $display("FAIL wrap_pub_timeout: got no write expected one"); end
        bus_a.ch_clear = 2'b10;
        @(negedge clk);
        bus_a.ch_clear = '0;
        n_checks++; if (bus_a.cnt_flat[7:4] !== 4'h0) begin n_fail++; $display("FAIL clear_cnt1: got %0h expected 0", bus_a.cnt_flat[7:4]); end
        n_checks++; if (bus_a.ovf !== 2'b00) begin n_fail++; $display("FAIL clear_ovf: got %0b expected 0", bus_a.ovf); end
    endtask

    task automatic test_snapshot();
        int s [NCH];
        int e;
        logic [31:0] exp_v, got_v;
        bit seen;
        bus.ch_clear = 4'hF;
        @(negedge clk);
        bus.ch_clear = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            bus.ch_start = NCH'(1) << i; s[i] = cyc + 1;
            @(negedge clk);
        end
        bus.ch_start = '0;
        repeat (5) @(negedge clk);
        bus.snap_req = 1'b1; e = cyc + 1;
        for (int i = 0; i < int'(NCH); i++) q_exp.push_back(32'(e - s[i]));
        @(negedge clk);
        bus.snap_req = 1'b0;
        n_checks++; if (bus.snap_busy !== 1'b1) begin n_fail++; $display("FAIL snap_busy_latch: got %0b expected 1", bus.snap_busy); end
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            if (dut.w_reg_we[0] === 1'b1) begin
                seen = 1'b1;
                n_checks++; if (dut.w_reg_we !== 5'b01111) begin n_fail++; $display("FAIL snap_we_data: got %0b expected 01111", dut.w_reg_we); end
                for (int i = 0; i < int'(NCH); i++) begin
                    exp_v = q_exp.pop_front();
                    got_v = dut.w_reg_d[i];
                    n_checks++; if (got_v !== exp_v) begin n_fail++; $display("FAIL snap_ch%0d: got %0d expected %0d", i, got_v, exp_v); end
                end
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) begin n_checks++; n_fail++; $display("FAIL snap_timeout: got no data write expected one"); end
        @(negedge clk);
        n_checks++; if (dut.w_reg_we !== 5'b10000) begin n_fail++; $display("FAIL snap_we_seq: got %0b expected 10000", dut.w_reg_we); end
        got_v = dut.w_reg_d[NCH];
        n_checks++; if (got_v !== 32'd1) begin n_fail++; $display("FAIL snap_seq_d: got %0d expected 1", got_v); end
        @(negedge clk);
        n_checks++; if (bus.seq_num !== 32'd1) begin n_fail++; $display("FAIL snap_seq_num: got %0d expected 1", bus.seq_num); end
        n_checks++; if (bus.snap_busy !== 1'b0) begin n_fail++; $display("FAIL snap_busy_done: got %0b expected 0", bus.snap_busy); end
        n_checks++; if (bus.cnt_flat[31:0] !== 32'(cyc - s[0])) begin n_fail++; $display("FAIL snap_no_stall: got %0d expected %0d", bus.cnt_flat[31:0], cyc - s[0]); end
    endtask

    task automatic test_back_to_back();
        int n_pub;
        logic [31:0] exp_v, got_v;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q_exp.delete();
        n_pub = 0;
        for (int k = 0; k < 24; k++) begin
            if (dut.w_reg_we[NCH] === 1'b1) begin
                n_pub++;
                got_v = dut.w_reg_d[NCH];
                if (q_exp.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL b2b_extra_pub: got %0d expected none", got_v);
                end else begin
                    exp_v = q_exp.pop_front();
                    n_checks++; if (got_v !== exp_v) begin n_fail++; $display("FAIL b2b_seq_d: got %0d expected %0d", got_v, exp_v); end
                end
            end
            bus.snap_req = (k == 0 || k == 2 || k == 3);
            if (k == 0) q_exp.push_back(32'd1);
            if (k == 2) q_exp.push_back(32'd2);
            @(negedge clk);
        end
        bus.snap_req = 1'b0;
        n_checks++; if (n_pub !== 2) begin n_fail++; $display("FAIL b2b_pub_count: got %0d expected 2", n_pub); end
        n_checks++; if (bus.seq_num !== 32'd2) begin n_fail++; $display("FAIL b2b_seq_num: got %0d expected 2", bus.seq_num); end
    endtask

    task automatic test_auto();
        int n_pub, busy_cycles, run;
        logic [7:0] exp_d, got_d;
        rst_n_a = 1'b0;
        @(negedge clk);
        rst_n_a = 1'b1;
        q_exp_a.delete();
        for (int i = 1; i <= 5; i++) q_exp_a.push_back(8'(i));
        n_pub = 0; busy_cycles = 0; run = 0;
        for (int k = 1; k <= 44; k++) begin
            @(negedge clk);
            if (bus_a.snap_busy === 1'b1) begin
                busy_cycles++; run++;
            end else if (run != 0) begin
                n_checks++; if (run !== 3) begin n_fail++; $display("FAIL auto_busy_run: got %0d expected 3", run); end
                run = 0;
            end
            if (dut_a.w_reg_we[NCH_A] === 1'b1) begin
                n_pub++;
                got_d = dut_a.w_reg_d[NCH_A];
                if (q_exp_a.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL auto_extra_pub: got %0d expected none", got_d);
                end else begin
                    exp_d = q_exp_a.pop_front();
                    n_checks++; if (got_d !== exp_d) begin n_fail++; $display("FAIL auto_seq_d: got %0d expected %0d", got_d, exp_d); end
                end
            end
        end
        n_checks++; if (n_pub !== 5) begin n_fail++; $display("FAIL auto_pub_count: got %0d expected 5", n_pub); end
        n_checks++; if (busy_cycles !== 15) begin n_fail++; $display("FAIL auto_busy_total: got %0d expected 15", busy_cycles); end
        n_checks++; if (bus_a.seq_num !== 8'd5) begin n_fail++; $display("FAIL auto_seq_num: got %0d expected 5", bus_a.seq_num); end
    endtask

    task automatic test_reset_abort();
        int n_we;
        bus.ch_start = 4'hF;
        @(negedge clk);
        bus.ch_start = '0;
        repeat (3) @(negedge clk);
        bus.snap_req = 1'b1;
        @(negedge clk);
        bus.snap_req = 1'b0;
        n_checks++; if (bus.snap_busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %0b expected 1", bus.snap_busy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.running !== 4'h0) begin n_fail++; $display("FAIL abort_running: got %0h expected 0", bus.running); end
        n_checks++; if (bus.cnt_flat !== '0) begin n_fail++; $display("FAIL abort_cnt: got %0h expected 0", bus.cnt_flat); end
        n_checks++; if (bus.snap_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %0b expected 0", bus.snap_busy); end
        n_checks++; if (bus.seq_num !== 32'd0) begin n_fail++; $display("FAIL abort_seq: got %0d expected 0", bus.seq_num); end
        n_checks++; if (dut.w_reg_we !== 5'b00000) begin n_fail++; $display("FAIL abort_we: got %0b expected 0", dut.w_reg_we); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_we = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (dut.w_reg_we[NCH] === 1'b1) n_we++;
        end
        n_checks++; if (n_we !== 0) begin n_fail++; $display("FAIL abort_seq_written: got %0d writes expected 0", n_we); end
        n_checks++; if (bus.seq_num !== 32'd0) begin n_fail++; $display("FAIL abort_seq_after: got %0d expected 0", bus.seq_num); end
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_snapshot();
        test_back_to_back();
        test_auto();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
